multicycle_ctrl: RTL and testbench

// Multi-cycle sequencer for the RV32 core: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a multi-cycle RV32 core,
// with ready-handshake waits, memory timeout trap, halt at instruction boundaries and counters.
module multicycle_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             halt_i,
   input  logic             imem_ready_i,
   input  logic             dmem_ready_i,
   input  logic [6:0]       opcode_i,
   input  logic             cond_true_i,
   output logic             imem_req_o,
   output logic             ir_we_o,
   output logic             pc_we_o,
   output logic [1:0]       pc_sel_o,
   output logic             alu_src_o,
   output logic             dmem_rd_o,
   output logic             dmem_wr_o,
   output logic             reg_we_o,
   output logic [1:0]       mem_to_reg_o,
   output logic             busy_o,
   output logic             illegal_o,
   output logic             timeout_err_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] instret_cnt_o
);
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE= 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam int WW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR} state_e;

   state_e           state_q, state_d;
   logic [6:0]       opcode_q, opcode_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic             illegal_q, illegal_d, timeout_q, timeout_d;
   logic [CNT_W-1:0] cycle_q, instret_q;
   logic             is_r, is_br, is_ld, is_st, is_jal, is_jalr, legal, wait_expired;
   state_e           boundary;

   assign is_r    = opcode_q == OP_R;
   assign is_br   = opcode_q == OP_BR;
   assign is_ld   = opcode_q == OP_LOAD;
   assign is_st   = opcode_q == OP_STORE;
   assign is_jal  = opcode_q == OP_JAL;
   assign is_jalr = opcode_q == OP_JALR;
   assign legal   = opcode_i inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR};
   assign wait_expired = wait_q == WW'(MEM_TIMEOUT - 1);
   // Every path into FETCH passes through here so halt is only honoured between instructions
   assign boundary = halt_i ? HALTED : FETCH;

   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      wait_d       = '0;
      illegal_d    = illegal_q;
      timeout_d    = timeout_q;
      imem_req_o   = 1'b0;
      ir_we_o      = 1'b0;
      pc_we_o      = 1'b0;
      pc_sel_o     = 2'd0;
      alu_src_o    = 1'b0;
      dmem_rd_o    = 1'b0;
      dmem_wr_o    = 1'b0;
      reg_we_o     = 1'b0;
      mem_to_reg_o = 2'd0;
      case (state_q)
         IDLE, HALTED: state_d = boundary;
         FETCH: begin
            imem_req_o = 1'b1;
            if (imem_ready_i) begin
               ir_we_o = 1'b1;
               state_d = DECODE;
            end else if (wait_expired) begin
               timeout_d = 1'b1;
               state_d   = ERROR;
            end else wait_d = wait_q + WW'(1);
         end
         DECODE: begin
            opcode_d  = opcode_i;
            illegal_d = illegal_q | ~legal;
            state_d   = legal ? EXEC : ERROR;
         end
         EXEC: begin
            alu_src_o = ~(is_r | is_br);
            pc_we_o   = is_br;
            pc_sel_o  = {1'b0, is_br & cond_true_i};
            state_d   = is_br ? boundary : (is_ld | is_st) ? MEM : WB;
         end
         MEM: begin
            dmem_rd_o = is_ld;
            dmem_wr_o = is_st;
            if (dmem_ready_i) begin
               pc_we_o = is_st;
               state_d = is_ld ? WB : boundary;
            end else if (wait_expired) begin
               timeout_d = 1'b1;
               state_d   = ERROR;
            end else wait_d = wait_q + WW'(1);
         end
         WB: begin
            reg_we_o     = 1'b1;
            pc_we_o      = 1'b1;
            mem_to_reg_o = is_ld ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : 2'd0;
            pc_sel_o     = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
            state_d      = boundary;
         end
         ERROR: state_d = ERROR;
      endcase
   end

   assign busy_o        = !(state_q inside {IDLE, HALTED, ERROR});
   assign illegal_o     = illegal_q;
   assign timeout_err_o = timeout_q;
   assign cycle_cnt_o   = cycle_q;
   assign instret_cnt_o = instret_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         opcode_q  <= '0;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
         if (busy_o) cycle_q <= cycle_q + CNT_W'(1);
         if (pc_we_o) instret_q <= instret_q + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random and directed instruction streams checked against a
// per-instruction latency/enable model derived from the sequencing rules.
module tb_multicycle_ctrl;
   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
   localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, BAD = 7'b1111111;

   logic clk = 0, rst_ni = 0, halt_i = 0, imem_ready_i = 0, dmem_ready_i = 0, cond_true_i = 0;
   logic [6:0] opcode_i = R;
   logic imem_req_o, ir_we_o, pc_we_o, alu_src_o, dmem_rd_o, dmem_wr_o, reg_we_o;
   logic busy_o, illegal_o, timeout_err_o;
   logic [1:0] pc_sel_o, mem_to_reg_o;
   logic [31:0] cycle_cnt_o, instret_cnt_o;

   int vectors = 0, miscompares = 0;
   int n_cyc, n_ir, n_pc, n_reg, n_rd, n_wr, viol, pcs, m2r, alu_seen;
   longint exp_cyc = 0, exp_ret = 0;
   logic [6:0] ops[7] = '{R, I, LD, ST, BR, JAL, JALR};

   multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .halt_i(halt_i), .imem_ready_i(imem_ready_i),
      .dmem_ready_i(dmem_ready_i), .opcode_i(opcode_i), .cond_true_i(cond_true_i),
      .imem_req_o(imem_req_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
      .alu_src_o(alu_src_o), .dmem_rd_o(dmem_rd_o), .dmem_wr_o(dmem_wr_o), .reg_we_o(reg_we_o),
      .mem_to_reg_o(mem_to_reg_o), .busy_o(busy_o), .illegal_o(illegal_o),
      .timeout_err_o(timeout_err_o), .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int lat(input logic [6:0] op, input int di, input int dd);
      return di + 3 + ((op == LD || op == ST) ? dd + 1 : 0) + ((op == BR || op == ST) ? 0 : 1);
   endfunction

   function automatic int exp_sel(input logic [6:0] op, input bit cond);
      return op == BR ? int'(cond) : op == JAL ? 1 : op == JALR ? 2 : 0;
   endfunction

   function automatic int exp_m2r(input logic [6:0] op);
      return op == LD ? 1 : (op == JAL || op == JALR) ? 2 : 0;
   endfunction

   task automatic idle_cyc();
      @(negedge clk);
      imem_ready_i = 0;
      dmem_ready_i = 0;
      #1;
   endtask

   // Drives one instruction: memories answer after di/dd wait cycles; returns on retire, trap or reset.
   task automatic run(input logic [6:0] op, input int di, input int dd, input bit cond,
                      input int halt_at, input int rst_at);
      int ic = 0, dc = 0;
      opcode_i = op;
      cond_true_i = cond;
      {n_cyc, n_ir, n_pc, n_reg, n_rd, n_wr, viol, pcs, m2r, alu_seen} = '0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (k == halt_at) halt_i = 1;
         imem_ready_i = imem_req_o && ic == di;
         dmem_ready_i = (dmem_rd_o || dmem_wr_o) && dc == dd;
         if (imem_req_o) ic++;
         if (dmem_rd_o || dmem_wr_o) dc++;
         #1;
         n_cyc += int'(busy_o);
         n_ir  += int'(ir_we_o);
         n_pc  += int'(pc_we_o);
         n_reg += int'(reg_we_o);
         n_rd  += int'(dmem_rd_o);
         n_wr  += int'(dmem_wr_o);
         if (pc_we_o) pcs = int'(pc_sel_o);
         if (reg_we_o) m2r = int'(mem_to_reg_o);
         if (alu_src_o) alu_seen = 1;
         if ((imem_req_o && (dmem_rd_o || dmem_wr_o)) ||
             (((imem_req_o && !imem_ready_i) || ((dmem_rd_o || dmem_wr_o) && !dmem_ready_i)) &&
              (ir_we_o || pc_we_o || reg_we_o))) viol++;
         if (k == rst_at) begin
            #2 rst_ni = 0;
            imem_ready_i = 0;
            dmem_ready_i = 0;
            #1 return;
         end
         if (pc_we_o || illegal_o || timeout_err_o) return;
      end
      chk("bound", pc_we_o, 1);
   endtask

   task automatic check_instr(input logic [6:0] op, input int di, input int dd, input bit cond,
                              input int halt_at);
      int l = lat(op, di, dd);
      bit wr = !(op == BR || op == ST);
      run(op, di, dd, cond, halt_at, -1);
      chk("latency", n_cyc, l);
      chk("ir_we", n_ir, 1);
      chk("pc_we", n_pc, 1);
      chk("reg_we", n_reg, wr ? 1 : 0);
      chk("pc_sel", pcs, exp_sel(op, cond));
      if (wr) chk("mem_to_reg", m2r, exp_m2r(op));
      chk("dmem_rd", n_rd, op == LD ? dd + 1 : 0);
      chk("dmem_wr", n_wr, op == ST ? dd + 1 : 0);
      chk("alu_src", alu_seen, (op == R || op == BR) ? 0 : 1);
      chk("hazard", viol, 0);
      chk("cycle_cnt", cycle_cnt_o, exp_cyc + l - 1);
      chk("instret", instret_cnt_o, exp_ret);
      exp_cyc += l;
      exp_ret++;
   endtask

   task automatic do_reset();
      rst_ni = 0;
      #1;
      chk("rst_cycle", cycle_cnt_o, 0);
      chk("rst_flags", {illegal_o, timeout_err_o, busy_o}, 0);
      @(negedge clk);
      rst_ni = 1;
      exp_cyc = 0;
      exp_ret = 0;
   endtask

   initial begin
      #2;
      chk("reset_busy", busy_o, 0);
      chk("reset_enables", {imem_req_o, ir_we_o, pc_we_o, reg_we_o, dmem_rd_o, dmem_wr_o, alu_src_o}, 0);
      chk("reset_counters", {cycle_cnt_o, instret_cnt_o}, 0);
      chk("reset_flags", {illegal_o, timeout_err_o}, 0);
      @(negedge clk);
      rst_ni = 1;
      check_instr(R, 0, 0, 0, -1);
      check_instr(LD, 0, 3, 0, -1);
      check_instr(BR, 0, 0, 1, -1);
      check_instr(BR, 0, 0, 0, -1);
      for (int n = 0; n < 24; n++)
         check_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom), -1);
      // halt raised during EXEC: instruction retires, then controller parks until halt drops
      check_instr(R, 0, 0, 0, 2);
      for (int n = 0; n < 3; n++) begin
         idle_cyc();
         chk("halted_idle", {busy_o, imem_req_o}, 0);
      end
      chk("halted_instret", instret_cnt_o, exp_ret);
      chk("halted_cycle", cycle_cnt_o, exp_cyc);
      @(negedge clk);
      halt_i = 0;
      #1 chk("halt_drop_cycle", busy_o, 0);
      check_instr(JAL, 1, 0, 0, -1);
      // illegal opcode traps to a terminal ERROR
      run(BAD, 0, 0, 0, -1, -1);
      chk("illegal_flag", illegal_o, 1);
      chk("illegal_no_pc_we", n_pc + n_reg, 0);
      for (int n = 0; n < 3; n++) begin
         idle_cyc();
         chk("error_terminal", {busy_o, imem_req_o, pc_we_o}, 0);
      end
      do_reset();
      // fetch timeout, then ready on the last allowed cycle
      run(R, 16, 0, 0, -1, -1);
      chk("imem_timeout", timeout_err_o, 1);
      chk("imem_timeout_busy", busy_o, 0);
      chk("imem_timeout_enables", n_ir + n_pc + n_reg, 0);
      do_reset();
      check_instr(R, 15, 0, 0, -1);
      chk("ready_at_limit", timeout_err_o, 0);
      run(LD, 0, 16, 0, -1, -1);
      chk("dmem_timeout", timeout_err_o, 1);
      chk("dmem_timeout_enables", n_pc + n_reg, 0);
      do_reset();
      // async reset in the middle of a STORE's memory wait
      run(ST, 0, 10, 0, -1, 4);
      chk("store_mem_cycles", n_wr, 2);
      chk("async_dmem_wr", dmem_wr_o, 0);
      chk("async_counters", {cycle_cnt_o, instret_cnt_o}, 0);
      @(negedge clk);
      rst_ni = 1;
      exp_cyc = 0;
      exp_ret = 0;
      #1 chk("post_reset_idle", {imem_req_o, busy_o, pc_we_o}, 0);
      check_instr(I, 0, 0, 0, -1);
      check_instr(JALR, 2, 0, 0, -1);
      check_instr(ST, 1, 2, 0, -1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
